// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch front end: exception bit
// positions, instruction-buffer entry layout and the default boot PC.
package if_pkg;

  localparam int unsigned EXC_PIF  = 3;
  localparam int unsigned EXC_PPI  = 2;
  localparam int unsigned EXC_ADEF = 1;
  localparam int unsigned EXC_TLBR = 0;
  localparam int unsigned EXC_W    = 4;

  localparam int unsigned PC_W = 32;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1c000000;

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [31:0]      inst;
    logic [EXC_W-1:0] exc;
  } ibuf_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Parametrised single-clock FIFO with occupancy count and synchronous clear.
// Push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             empty, full, do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CntW'(Depth));
  assign do_pop  = pop_i & ~empty;
  assign do_push = push_i & (~full | do_pop);

  always_comb begin
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    cnt_d  = cnt_q;
    if (clr_i) begin
      rptr_d = '0;
      wptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (do_push) wptr_d = ptr_inc(wptr_q);
      if (do_pop)  rptr_d = ptr_inc(rptr_q);
      if (do_push && !do_pop)      cnt_d = cnt_q + CntW'(1);
      else if (do_pop && !do_push) cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !clr_i) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/if_fetch_buffer.sv
// Instruction-fetch front end: issues up to MAX_OUTSTANDING bus requests and
// buffers returned instructions; redirects discard stale responses by count.
module if_fetch_buffer
  import if_pkg::*;
#(
  parameter int unsigned       ADDR_W          = 32,
  parameter logic [ADDR_W-1:0] RESET_PC        = ADDR_W'(RESET_PC_DEFAULT),
  parameter int unsigned       MAX_OUTSTANDING = 2,
  parameter int unsigned       IBUF_DEPTH      = 4,
  parameter int unsigned       NUM_REDIRECT    = 6
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [NUM_REDIRECT-1:0]    redirect_valid,
  input  logic [NUM_REDIRECT*ADDR_W-1:0] redirect_pc,
  input  logic [2:0]                 s0_exc,
  output logic [ADDR_W-1:0]          pre_if_vaddr,
  output logic                       inst_sram_req,
  output logic                       inst_sram_wr,
  output logic [1:0]                 inst_sram_size,
  output logic [3:0]                 inst_sram_wstrb,
  output logic [31:0]                inst_sram_wdata,
  input  logic                       inst_sram_addr_ok,
  input  logic                       inst_sram_data_ok,
  input  logic [31:0]                inst_sram_rdata,
  input  logic                       id_allowin,
  output logic                       if_to_id_valid,
  output logic [31:0]                if_inst,
  output logic [ADDR_W-1:0]          if_pc,
  output logic [3:0]                 if_exc
);

  localparam int unsigned InfW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned CntW = $clog2(IBUF_DEPTH + 1);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [InfW-1:0]   cancel_q, cancel_d;
  logic              exc_stall_q, exc_stall_d;

  logic [InfW-1:0]   inflight;
  logic [ADDR_W-1:0] pcq_head;
  logic [CntW-1:0]   ibuf_cnt;
  logic              ibuf_full;
  ibuf_entry_t       ibuf_wdata, ibuf_head;

  logic              redirect_any;
  logic [ADDR_W-1:0] redirect_target;
  logic [3:0]        pre_exc;
  logic              accept, resp_keep, exc_push, ibuf_push, ibuf_pop;
  logic [31:0]       reserved;

  assign redirect_any = |redirect_valid;

  // Scan from the top so the lowest set index wins.
  always_comb begin
    redirect_target = '0;
    for (int i = int'(NUM_REDIRECT) - 1; i >= 0; i--) begin
      if (redirect_valid[i]) redirect_target = redirect_pc[i*ADDR_W +: ADDR_W];
    end
  end

  always_comb begin
    pre_exc           = '0;
    pre_exc[EXC_PIF]  = s0_exc[2];
    pre_exc[EXC_PPI]  = s0_exc[1];
    pre_exc[EXC_ADEF] = |pc_q[1:0];
    pre_exc[EXC_TLBR] = s0_exc[0];
  end

  // Live (non-cancelled) requests already hold a buffer slot.
  assign reserved = 32'(inflight) - 32'(cancel_q) + 32'(ibuf_cnt);

  assign inst_sram_req = ~resetn & ~redirect_any & ~exc_stall_q & ~|pre_exc &
                         (32'(inflight) < MAX_OUTSTANDING) & (reserved < IBUF_DEPTH);

  assign accept    = inst_sram_req & inst_sram_addr_ok;
  assign resp_keep = inst_sram_data_ok & (cancel_q == '0) & ~redirect_any;
  assign ibuf_full = (ibuf_cnt == CntW'(IBUF_DEPTH));
  assign exc_push  = |pre_exc & (inflight == '0) & ~redirect_any & ~ibuf_full & ~exc_stall_q;
  assign ibuf_push = resp_keep | exc_push;
  assign ibuf_pop  = if_to_id_valid & id_allowin;

  always_comb begin
    pc_d        = pc_q;
    cancel_d    = cancel_q;
    exc_stall_d = exc_stall_q;
    if (accept) pc_d = pc_q + ADDR_W'(4);
    if (redirect_any) begin
      pc_d        = redirect_target;
      exc_stall_d = 1'b0;
      cancel_d    = inflight - InfW'(inst_sram_data_ok);
    end else if (inst_sram_data_ok && cancel_q != '0) begin
      cancel_d = cancel_q - InfW'(1);
    end
    if (exc_push) exc_stall_d = 1'b1;
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      pc_q        <= RESET_PC;
      cancel_q    <= '0;
      exc_stall_q <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      cancel_q    <= cancel_d;
      exc_stall_q <= exc_stall_d;
    end
  end

  // The PC queue occupancy is exactly the in-flight request count.
  sync_fifo #(
    .Width (ADDR_W),
    .Depth (MAX_OUTSTANDING)
  ) u_pc_queue (
    .clk_i   (clk),
    .rst_i   (resetn),
    .clr_i   (1'b0),
    .push_i  (accept),
    .wdata_i (pc_q),
    .pop_i   (inst_sram_data_ok),
    .rdata_o (pcq_head),
    .count_o (inflight)
  );

  always_comb begin
    ibuf_wdata = '0;
    if (exc_push) begin
      ibuf_wdata.pc  = PC_W'(pc_q);
      ibuf_wdata.exc = pre_exc;
    end else begin
      ibuf_wdata.pc   = PC_W'(pcq_head);
      ibuf_wdata.inst = inst_sram_rdata;
    end
  end

  sync_fifo #(
    .Width ($bits(ibuf_entry_t)),
    .Depth (IBUF_DEPTH)
  ) u_ibuf (
    .clk_i   (clk),
    .rst_i   (resetn),
    .clr_i   (redirect_any),
    .push_i  (ibuf_push),
    .wdata_i (ibuf_wdata),
    .pop_i   (ibuf_pop),
    .rdata_o (ibuf_head),
    .count_o (ibuf_cnt)
  );

  assign if_to_id_valid = (ibuf_cnt != '0);
  assign if_inst = if_to_id_valid ? ibuf_head.inst : '0;
  assign if_pc   = if_to_id_valid ? ADDR_W'(ibuf_head.pc) : '0;
  assign if_exc  = if_to_id_valid ? ibuf_head.exc : '0;

  assign pre_if_vaddr    = pc_q;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'b10;
  assign inst_sram_wstrb = 4'b0;
  assign inst_sram_wdata = 32'b0;

endmodule
